bus_source_arbiter: RTL and testbench

- Sequential arbiter that sits directly upstream of the 32-to-1 datapath bus multiplexer.
- Takes up to 32 "drive bus" request lines from register-out and control-out enables.
- Grants exactly one source using round-robin with a hold limit.
- Produces the registered 5-bit select code that steers the bus mux, plus a one-hot grant and a bus-valid flag, so multiple drivers can never be selected at once.

---
 rtl/bus_source_arbiter_pkg.sv | 32 +++
 rtl/bus_source_arbiter_rr_priority_encoder.sv | 33 +++
 rtl/bus_source_arbiter.sv | 100 ++++++++++
 tb/tb_bus_source_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_source_arbiter_pkg.sv
// Shared definitions for the bus source arbiter and its round-robin encoder.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package bus_source_arbiter_pkg;

    // The bus mux is fixed at 32 inputs, so the select code is 5 bits.
    localparam int N_SRC = 32;
    localparam int SEL_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Source indices used by the control unit when it assembles req.
    // General registers R0..R15 occupy indices 0..15; 24..31 are spare.
    localparam int SRC_R0     = 0;
    localparam int SRC_R15    = 15;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int SRC_CSIGN  = 23;

    function automatic logic [N_SRC-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return N_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_priority_encoder.sv
// Round-robin priority encoder: first set bit of req at or after start, wrapping mod 32.
// Latency: purely combinational.
// Backpressure: none; found=0 when req is all zero (idx is then start).
// Ports: req - request vector; start - first index to consider;
//        idx - winning index; found - at least one request present.
module rr_priority_encoder
    import bus_source_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_SRC-1:0] rotated;
    logic [SEL_W-1:0] offset;

    always_comb begin
        // Rotate right by start so that index start lands on bit 0.
        rotated = N_SRC'({req, req} >> start);
        // Fixed priority: lowest set bit wins; scan high-to-low so the last hit is the lowest.
        offset  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SEL_W'(i);
            end
        end
        found = |rotated;
        // Add-back wraps naturally in SEL_W bits.
        idx   = start + offset;
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus source arbiter with a hold limit, driving the 32:1 datapath bus mux select.
// Latency: a request present before an edge is granted at that edge; outputs fully registered.
// Backpressure: owner keeps the bus until it drops req or, while others wait, for MAX_HOLD cycles.
// Ports: clk - clock; clr - async active-high reset; req - per-source drive requests;
//        sel - mux select code; grant - one-hot grant; bus_valid - bus owned this cycle;
//        hold_cnt - cycles the current owner has held the bus (saturating).
module bus_source_arbiter
    import bus_source_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] grant,
    output logic             bus_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             owner_req;
    logic             others_req;
    logic             preempt;

    assign owner_req  = req[sel];
    // grant holds exactly the owner while in OWN, so this is "anyone else asking".
    assign others_req = |(req & ~grant);
    assign preempt    = (state == OWN) && owner_req && (MAX_HOLD != 0) &&
                        (hold_cnt == HOLD_LAST) && others_req;

    // On preemption search starts just past the owner so the owner is considered last.
    assign start = preempt ? (sel + SEL_W'(1)) : ptr;

    rr_priority_encoder u_rr_enc (
        .req   (req),
        .start (start),
        .idx   (win_idx),
        .found (win_found)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            sel       <= '0;
            grant     <= '0;
            bus_valid <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // sel is left alone when nothing is granted so the mux input stays steady.
                    if (win_found) begin
                        state     <= OWN;
                        sel       <= win_idx;
                        grant     <= idx_to_onehot(win_idx);
                        bus_valid <= 1'b1;
                        hold_cnt  <= '0;
                        ptr       <= win_idx + SEL_W'(1);
                    end
                end
                OWN: begin
                    if (!owner_req || preempt) begin
                        // Owner not requesting means win_found reflects only other sources.
                        if (win_found) begin
                            sel       <= win_idx;
                            grant     <= idx_to_onehot(win_idx);
                            bus_valid <= 1'b1;
                            hold_cnt  <= '0;
                            ptr       <= win_idx + SEL_W'(1);
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            bus_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    bus_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_source_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int HOLD_SAT = 15;
    localparam int WAIT_BOUND = 31 * MAX_HOLD + 31;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] req;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic        bus_valid;
    logic [3:0]  hold_cnt;

    bus_source_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .sel       (sel),
        .grant     (grant),
        .bus_valid (bus_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Behavioural model: who owns the bus, for how long, and where the next search starts.
    bit m_valid;
    int m_sel;
    int m_hold;
    int m_ptr;

    function automatic int rr_pick(input logic [31:0] r, input int from);
        for (int i = 0; i < 32; i++) begin
            if (r[(from + i) % 32]) return (from + i) % 32;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sel = 0; m_hold = 0; m_ptr = 0;
    endtask

    task automatic model_grant(input int w);
        m_valid = 1; m_sel = w; m_hold = 0; m_ptr = (w + 1) % 32;
    endtask

    task automatic model_step(input logic [31:0] r);
        logic [31:0] others;
        int w;
        if (!m_valid) begin
            w = rr_pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else if (!r[m_sel]) begin
            w = rr_pick(r, m_ptr);
            if (w >= 0) model_grant(w);
            else begin m_valid = 0; m_hold = 0; end
        end else begin
            others = r & ~(32'd1 << m_sel);
            if (m_hold == MAX_HOLD - 1 && others != 0)
                model_grant(rr_pick(others, (m_sel + 1) % 32));
            else if (m_hold < HOLD_SAT)
                m_hold++;
        end
    endtask

    task automatic compare_all();
        check("sel", 32'(sel), 32'(m_sel));
        check("grant", grant, m_valid ? (32'd1 << m_sel) : 32'd0);
        check("bus_valid", 32'(bus_valid), 32'(m_valid));
        check("hold_cnt", 32'(hold_cnt), 32'(m_hold));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("grant_sel", 32'(grant[sel]), 32'(bus_valid));
    endtask

    // One clock: model consumes the req seen at the edge, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step(req);
        #1;
        compare_all();
    endtask

    int          waited [32];
    int          max_wait;
    logic [31:0] req_at_edge;
    logic [31:0] nxt;

    initial begin
        clr = 1'b1;
        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        clr = 1'b0;

        // Single request, then release to idle with sel retained.
        req = 32'h0000_0010;
        tick();
        check("single_sel", 32'(sel), 32'd4);
        check("single_grant", grant, 32'h10);
        req = '0;
        tick();
        check("idle_valid", 32'(bus_valid), 32'd0);
        check("idle_sel_kept", 32'(sel), 32'd4);

        // Round-robin from ptr=5 wraps to 0, then back-to-back to 3.
        req = 32'h0000_0009;
        tick();
        check("rr_wrap_sel", 32'(sel), 32'd0);
        req = 32'h0000_0008;
        tick();
        check("rr_b2b_sel", 32'(sel), 32'd3);
        req = '0;
        tick();

        // Hold-limit preemption between sources 2 and 20.
        req = 32'd1 << 2;
        tick();
        req = (32'd1 << 2) | (32'd1 << 20);
        repeat (7) tick();
        check("hold_last_cnt", 32'(hold_cnt), 32'd7);
        tick();
        check("preempt_sel", 32'(sel), 32'd20);
        repeat (8) tick();
        check("regain_sel", 32'(sel), 32'd2);
        req = '0;
        tick();

        // Wrap-around preemption from 31 to 0.
        req = 32'd1 << 31;
        tick();
        req = (32'd1 << 31) | 32'd1;
        repeat (8) tick();
        check("wrap_sel", 32'(sel), 32'd0);
        req = '0;
        tick();

        // Async reset in the middle of a grant.
        req = 32'd1 << 18;
        tick();
        tick();
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check("arst_grant", grant, 32'd0);
        check("arst_valid", 32'(bus_valid), 32'd0);
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_hold", 32'(hold_cnt), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        tick();
        check("post_arst_sel", 32'(sel), 32'd18);

        // Randomized traffic: sticky requesters first, then sparse noise.
        foreach (waited[i]) waited[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c < 6000) begin
                nxt = '0;
                for (int i = 0; i < 32; i++) begin
                    if (req[i]) nxt[i] = !(grant[i] && $urandom_range(3) == 0);
                    else        nxt[i] = ($urandom_range(7) == 0);
                end
                req = nxt;
            end else begin
                req = $urandom & $urandom & $urandom;
            end
            req_at_edge = req;
            tick();
            for (int i = 0; i < 32; i++) begin
                if (req_at_edge[i] && !grant[i]) waited[i]++;
                else waited[i] = 0;
                if (waited[i] > max_wait) max_wait = waited[i];
            end
        end
        check("max_wait_bounded", 32'(max_wait <= WAIT_BOUND), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
